execute: RTL and testbench
==========================

EXECUTE -- requirements
Module: execute

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock; single clock domain.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have inputs wb_ctrl[1:0], branch_in, mem_read_in, mem_write_in, which are ID/EX control passed through.
REQ-005 SHALL have inputs reg_dst, alu_src and alu_op[1:0], which are EX control.
REQ-006 SHALL have inputs npc[31:0], read_data1[31:0], read_data2[31:0] and sign_ext[31:0], which are ID/EX data.
REQ-007 SHALL have inputs rt[4:0] and rd[4:0], which are destination candidates.
REQ-008 SHALL have input flush (1), the branch-taken squash from the memory stage pc_src.
REQ-009 SHALL have outputs wb_ctrl_out[1:0], branch, mem_read, mem_write, zero, alu_result[31:0], write_data[31:0], write_reg[4:0] and branch_target[31:0], all registered EX/MEM values.
REQ-010 SHALL have output stall (1), combinational, which holds PC, IF/ID and ID/EX upstream while high.

Function
REQ-011 SHALL compute operand B as sign_ext when alu_src=1, else read_data2.
REQ-012 SHALL decode alu_op as: 00 -> add; 01 -> sub; 10 -> funct=sign_ext[5:0] with 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed), 0x18 mult; 11 or unknown funct -> result 0.
REQ-013 SHALL wrap add/sub modulo 2^32 with no overflow flag; slt yields 32'd1 or 32'd0.
REQ-014 SHALL set zero to 1 exactly when the ALU result equals 0.
REQ-015 SHALL compute branch_target as npc + (sign_ext << 2), modulo 2^32.
REQ-016 SHALL select write_reg = rd when reg_dst=1, else rt.
REQ-017 SHALL pass write_data = read_data2 unmodified.
REQ-018 SHALL, for single-cycle ops, capture all EX/MEM outputs on the next rising edge, giving 1-cycle latency.
REQ-019 SHALL implement mult as a 32-iteration shift-add unit returning the low 32 bits of the unsigned product, using FSM IDLE/BUSY/DONE.
REQ-020 SHALL, in IDLE with a decoded mult and flush=0, latch operands, clear the iteration counter, assert stall combinationally that cycle, and go to BUSY.
REQ-021 SHALL, in BUSY, perform one iteration per cycle with stall=1; after iteration 31 (counter 5-bit wrap 31->0) it SHALL go to DONE.
REQ-022 SHALL, in DONE, hold stall=0, capture the product and the held instruction's controls into EX/MEM, and return to IDLE; stall is high for exactly 33 cycles per mult.
REQ-023 SHALL capture a bubble (wb_ctrl_out, branch, mem_read, mem_write = 0) into EX/MEM on every edge while stall=1.
REQ-024 SHALL, on flush=1, capture a bubble with all EX/MEM outputs zero at the next edge, regardless of state.
REQ-025 SHALL, on flush in BUSY or DONE, abort to IDLE, drop the product and deassert stall next cycle; flush has priority over stall and mult issue.
REQ-026 SHALL NOT issue a mult when flush and mult decode coincide in IDLE.

Reset
REQ-027 SHALL, while rst=1, asynchronously force all registered outputs to 0, the FSM to IDLE, the counter to 0 and the multiplier registers to 0.
REQ-028 SHALL hold stall=0 during reset; a mult in progress when reset asserts is discarded.
REQ-029 SHALL treat the first edge after rst deasserts as a normal capture.

Structure
REQ-030 SHALL place the alu_op encodings, funct codes and FSM state enum in the shared CPU package.
REQ-031 SHALL implement the EX/MEM register as sub-module ex_mem_latch, with bubble and flush inputs; the ALU and multiplier FSM stay in execute.

Verification
REQ-032 SHALL cover: alu_op=10, funct 0x22, A=5, B=5 -> next edge alu_result=0, zero=1.
REQ-033 SHALL cover: alu_op=00, alu_src=1, A=0x1000, sign_ext=0xFFFFFFFC -> alu_result=0x00000FFC, write_reg=rt.
REQ-034 SHALL cover: slt with A=0xFFFFFFFF, B=1 -> alu_result=1; npc=0x40, sign_ext=3 -> branch_target=0x4C.
REQ-035 SHALL cover: mult A=7, B=0x10000001 -> stall high for 33 cycles with bubbles; then alu_result=0x70000007 with controls intact and stall low.
REQ-036 SHALL cover: flush asserted in BUSY iteration 10 -> stall low next cycle, EX/MEM all zero, FSM in IDLE; a following add issues normally.
REQ-037 SHALL cover: rst asserted mid-BUSY, asynchronously between edges -> all outputs 0 immediately and stall=0.

Source files
------------

// File: rtl/execute_pkg.sv
// execute_pkg
// Shared CPU definitions for the execute stage. It holds the alu_op
// encodings, the R-type funct codes, the multiplier FSM state enum and the
// packed EX/MEM payload types.
package execute_pkg;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_NONE  = 2'b11
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_MULT = 6'h18;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_BUSY,
        MUL_DONE
    } mul_state_e;

    // Full EX/MEM register contents.
    typedef struct packed {
        logic [1:0]  wb_ctrl;
        logic        branch;
        logic        mem_read;
        logic        mem_write;
        logic        zero;
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [4:0]  write_reg;
        logic [31:0] branch_target;
    } ex_mem_t;

    // The parts of a mult instruction that are kept while the product is built.
    typedef struct packed {
        logic [1:0]  wb_ctrl;
        logic        branch;
        logic        mem_read;
        logic        mem_write;
        logic [31:0] write_data;
        logic [4:0]  write_reg;
        logic [31:0] branch_target;
    } mul_hold_t;

endpackage

// File: rtl/execute_ex_mem_latch.sv
// ex_mem_latch
// EX/MEM pipeline register.
//   clk, rst : clock and asynchronous active-high reset
//   bubble   : the stage is stalled; capture d with every control bit cleared
//   flush    : squash; capture all zeros (takes priority over bubble)
//   d / q    : next and current EX/MEM contents
module ex_mem_latch
    import execute_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    bubble,
    input  logic    flush,
    input  ex_mem_t d,
    output ex_mem_t q
);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else begin
            q <= d;
            if (bubble) begin
                q.wb_ctrl   <= 2'b00;
                q.branch    <= 1'b0;
                q.mem_read  <= 1'b0;
                q.mem_write <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/execute.sv
// execute
// Pipeline execute stage. It contains the ALU, the branch target adder, the
// destination register mux and a 32-cycle shift-add multiplier. It drives
// the EX/MEM register.
//   inputs  : ID/EX controls and data, rt/rd, and flush (taken-branch squash)
//   outputs : registered EX/MEM fields, and a combinational stall that holds
//             PC, IF/ID and ID/EX while a mult is in flight
module execute
    import execute_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        wb_ctrl,
    input  logic              branch_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              reg_dst,
    input  logic              alu_src,
    input  logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] npc,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    input  logic [DATA_W-1:0] sign_ext,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic              flush,
    output logic [1:0]        wb_ctrl_out,
    output logic              branch,
    output logic              mem_read,
    output logic              mem_write,
    output logic              zero,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] write_data,
    output logic [4:0]        write_reg,
    output logic [DATA_W-1:0] branch_target,
    output logic              stall
);

    alu_op_e           op;
    logic [5:0]        funct;
    logic [DATA_W-1:0] op_a, op_b, alu_res;
    logic              is_mult, issue;

    mul_state_e        state;
    logic [4:0]        count;
    logic [DATA_W-1:0] mcand, mplier, prod;
    mul_hold_t         held;

    ex_mem_t           live, latch_d, latch_q;

    assign op      = alu_op_e'(alu_op);
    assign funct   = sign_ext[5:0];
    assign op_a    = read_data1;
    assign op_b    = alu_src ? sign_ext : read_data2;
    assign is_mult = (op == ALU_FUNCT) && (funct == FUNCT_MULT);

    // A flush in the issue cycle cancels the mult before it starts.
    assign issue = (state == MUL_IDLE) && is_mult && !flush;
    assign stall = !rst && (issue || (state == MUL_BUSY));

    // mult does not produce a result here. Its product is taken from the FSM in DONE.
    // NOTE: each variable in an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        alu_res = '0;
        case (op)
            ALU_ADD: alu_res = op_a + op_b;
            ALU_SUB: alu_res = op_a - op_b;
            ALU_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_res = op_a + op_b;
                    FUNCT_SUB: alu_res = op_a - op_b;
                    FUNCT_AND: alu_res = op_a & op_b;
                    FUNCT_OR:  alu_res = op_a | op_b;
                    FUNCT_SLT: alu_res = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                    default:   alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        live.wb_ctrl       = wb_ctrl;
        live.branch        = branch_in;
        live.mem_read      = mem_read_in;
        live.mem_write     = mem_write_in;
        live.zero          = (alu_res == '0);
        live.alu_result    = alu_res;
        live.write_data    = read_data2;
        live.write_reg     = reg_dst ? rd : rt;
        live.branch_target = npc + (sign_ext << 2);
    end

    // In DONE, the EX/MEM register receives the finished product and the
    // controls that were saved at issue. In every other state it receives
    // the live ALU path.
    always_comb begin
        latch_d = live;
        if (state == MUL_DONE) begin
            latch_d.wb_ctrl       = held.wb_ctrl;
            latch_d.branch        = held.branch;
            latch_d.mem_read      = held.mem_read;
            latch_d.mem_write     = held.mem_write;
            latch_d.zero          = (prod == '0);
            latch_d.alu_result    = prod;
            latch_d.write_data    = held.write_data;
            latch_d.write_reg     = held.write_reg;
            latch_d.branch_target = held.branch_target;
        end
    end

    // Shift-add multiplier. Each BUSY cycle adds the shifted multiplicand
    // when the current multiplier LSB is set. Only the low DATA_W bits are kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= MUL_IDLE;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            held   <= '0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (issue) begin
                        mcand  <= op_a;
                        mplier <= op_b;
                        prod   <= '0;
                        count  <= '0;
                        held   <= '{wb_ctrl: wb_ctrl, branch: branch_in,
                                    mem_read: mem_read_in, mem_write: mem_write_in,
                                    write_data: live.write_data, write_reg: live.write_reg,
                                    branch_target: live.branch_target};
                        state  <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    if (flush) begin
                        state <= MUL_IDLE;
                    end else begin
                        if (mplier[0]) prod <= prod + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        count  <= count + 5'd1;
                        if (count == 5'd31) state <= MUL_DONE;
                    end
                end
                MUL_DONE: state <= MUL_IDLE;
                default:  state <= MUL_IDLE;
            endcase
        end
    end

    ex_mem_latch u_ex_mem (
        .clk    (clk),
        .rst    (rst),
        .bubble (stall),
        .flush  (flush),
        .d      (latch_d),
        .q      (latch_q)
    );

    assign wb_ctrl_out   = latch_q.wb_ctrl;
    assign branch        = latch_q.branch;
    assign mem_read      = latch_q.mem_read;
    assign mem_write     = latch_q.mem_write;
    assign zero          = latch_q.zero;
    assign alu_result    = latch_q.alu_result;
    assign write_data    = latch_q.write_data;
    assign write_reg     = latch_q.write_reg;
    assign branch_target = latch_q.branch_target;

endmodule

// File: tb/tb_execute.sv
// tb_execute
// Scoreboard bench for the execute stage. Each driven cycle pushes the
// expected EX/MEM contents, and a monitor pops and compares them 1 ns after
// the next rising edge. stall is checked by the driver.
module tb_execute;
    import execute_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  wb_ctrl = '0;
    logic        branch_in = 1'b0, mem_read_in = 1'b0, mem_write_in = 1'b0;
    logic        reg_dst = 1'b0, alu_src = 1'b0;
    logic [1:0]  alu_op = '0;
    logic [31:0] npc = '0, read_data1 = '0, read_data2 = '0, sign_ext = '0;
    logic [4:0]  rt = '0, rd = '0;
    logic        flush = 1'b0;
    logic [1:0]  wb_ctrl_out;
    logic        branch, mem_read, mem_write, zero, stall;
    logic [31:0] alu_result, write_data, branch_target;
    logic [4:0]  write_reg;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  wb;
        logic        br, mr, mw, reg_dst, alu_src;
        logic [1:0]  op;
        logic [31:0] npc, rd1, rd2, se;
        logic [4:0]  rt, rd;
    } instr_t;

    typedef enum {E_FULL, E_BUBBLE, E_ZERO} exp_kind_e;

    typedef struct {
        exp_kind_e   kind;
        string       name;
        logic [1:0]  wb;
        logic        br, mr, mw, zero;
        logic [31:0] res, wd, bt;
        logic [4:0]  wr;
    } exp_t;

    exp_t sb_q[$];

    execute #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .wb_ctrl(wb_ctrl), .branch_in(branch_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .reg_dst(reg_dst), .alu_src(alu_src), .alu_op(alu_op), .npc(npc),
        .read_data1(read_data1), .read_data2(read_data2), .sign_ext(sign_ext),
        .rt(rt), .rd(rd), .flush(flush), .wb_ctrl_out(wb_ctrl_out),
        .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
        .zero(zero), .alu_result(alu_result), .write_data(write_data),
        .write_reg(write_reg), .branch_target(branch_target), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic instr_t ins(input logic [1:0] op, input logic src, input logic dst,
                                   input logic [31:0] rd1, input logic [31:0] rd2,
                                   input logic [31:0] se, input logic [31:0] pc);
        instr_t s;
        s.wb = 2'b10; s.br = 1'b0; s.mr = 1'b0; s.mw = 1'b0;
        s.reg_dst = dst; s.alu_src = src; s.op = op;
        s.npc = pc; s.rd1 = rd1; s.rd2 = rd2; s.se = se;
        s.rt = 5'd9; s.rd = 5'd17;
        return s;
    endfunction

    // Reference behaviour of one instruction as captured into EX/MEM.
    function automatic exp_t model(input string name, input instr_t s);
        exp_t e;
        logic [31:0] b, r;
        b = s.alu_src ? s.se : s.rd2;
        r = 32'd0;
        if (s.op == 2'b00) r = s.rd1 + b;
        else if (s.op == 2'b01) r = s.rd1 - b;
        else if (s.op == 2'b10) begin
            case (s.se[5:0])
                6'h20: r = s.rd1 + b;
                6'h22: r = s.rd1 - b;
                6'h24: r = s.rd1 & b;
                6'h25: r = s.rd1 | b;
                6'h2A: r = ($signed(s.rd1) < $signed(b)) ? 32'd1 : 32'd0;
                6'h18: r = s.rd1 * b;
                default: r = 32'd0;
            endcase
        end
        e.kind = E_FULL; e.name = name;
        e.wb = s.wb; e.br = s.br; e.mr = s.mr; e.mw = s.mw;
        e.res = r; e.zero = (r == 32'd0);
        e.wd = s.rd2;
        e.wr = s.reg_dst ? s.rd : s.rt;
        e.bt = s.npc + (s.se << 2);
        return e;
    endfunction

    function automatic exp_t marker(input exp_kind_e k, input string name);
        exp_t e;
        e.kind = k; e.name = name;
        e.wb = '0; e.br = 0; e.mr = 0; e.mw = 0; e.zero = 0;
        e.res = '0; e.wd = '0; e.bt = '0; e.wr = '0;
        return e;
    endfunction

    task automatic apply(input instr_t s);
        wb_ctrl = s.wb; branch_in = s.br; mem_read_in = s.mr; mem_write_in = s.mw;
        reg_dst = s.reg_dst; alu_src = s.alu_src; alu_op = s.op;
        npc = s.npc; read_data1 = s.rd1; read_data2 = s.rd2; sign_ext = s.se;
        rt = s.rt; rd = s.rd;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ctrl"}, {26'd0, wb_ctrl_out, branch, mem_read, mem_write, zero}, 32'd0);
        check({tag, ".res"}, alu_result, 32'd0);
        check({tag, ".wd"}, write_data, 32'd0);
        check({tag, ".wr"}, {27'd0, write_reg}, 32'd0);
        check({tag, ".bt"}, branch_target, 32'd0);
    endtask

    // Single-cycle instruction: no stall, result one edge later.
    task automatic do_op(input string name, input instr_t s);
        apply(s);
        flush = 1'b0;
        #1 check({name, ".stall"}, {31'd0, stall}, 32'd0);
        sb_q.push_back(model(name, s));
        @(negedge clk);
    endtask

    task automatic do_flush_op(input string name, input instr_t s);
        apply(s);
        flush = 1'b1;
        #1 check({name, ".stall"}, {31'd0, stall}, 32'd0);
        sb_q.push_back(marker(E_ZERO, name));
        @(negedge clk);
        flush = 1'b0;
    endtask

    // Issue a mult and hold it for n stalled cycles, each expected to capture a bubble.
    task automatic mult_stall(input string name, input instr_t s, input int n);
        apply(s);
        flush = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1 check($sformatf("%s.stall%0d", name, i), {31'd0, stall}, 32'd1);
            sb_q.push_back(marker(E_BUBBLE, name));
            @(negedge clk);
        end
    endtask

    // Monitor: compare one scoreboard entry per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                case (e.kind)
                    E_FULL: begin
                        check({e.name, ".ctrl"}, {26'd0, wb_ctrl_out, branch, mem_read, mem_write, zero},
                              {26'd0, e.wb, e.br, e.mr, e.mw, e.zero});
                        check({e.name, ".res"}, alu_result, e.res);
                        check({e.name, ".wd"}, write_data, e.wd);
                        check({e.name, ".wr"}, {27'd0, write_reg}, {27'd0, e.wr});
                        check({e.name, ".bt"}, branch_target, e.bt);
                    end
                    E_BUBBLE: check({e.name, ".bubble"},
                                    {28'd0, wb_ctrl_out, branch, mem_read, mem_write}, 32'd0);
                    default: check_all_zero(e.name);
                endcase
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t s, m;
        logic [5:0] fl;
        logic [5:0] functs [6];
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};

        // Reset. A mult is decoded on the inputs, but stall must stay low.
        #1 rst = 1'b1;
        m = ins(2'b10, 1'b0, 1'b1, 32'd7, 32'h1000_0001, 32'h0000_0018, 32'h100);
        apply(m);
        @(negedge clk);
        #1 check("reset.stall", {31'd0, stall}, 32'd0);
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // The first edge after reset is a normal capture (funct 0x22, 5-5).
        do_op("sub_zero", ins(2'b10, 1'b0, 1'b1, 32'd5, 32'd5, 32'h0000_0022, 32'h0));
        do_op("addi_neg", ins(2'b00, 1'b1, 1'b0, 32'h1000, 32'h55, 32'hFFFF_FFFC, 32'h4));
        do_op("slt_neg", ins(2'b10, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h0000_002A, 32'h8));
        s = ins(2'b01, 1'b0, 1'b0, 32'd9, 32'd4, 32'd3, 32'h40);
        s.br = 1'b1; s.wb = 2'b00;
        do_op("beq_tgt", s);
        do_op("add_wrap", ins(2'b00, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0));
        do_op("op11", ins(2'b11, 1'b0, 1'b1, 32'd3, 32'd4, 32'h20, 32'h0));
        do_op("bad_funct", ins(2'b10, 1'b0, 1'b1, 32'd3, 32'd4, 32'h3F, 32'h0));
        do_op("and", ins(2'b10, 1'b0, 1'b1, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h24, 32'h0));
        do_op("or", ins(2'b10, 1'b0, 1'b1, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h25, 32'h0));

        for (int i = 0; i < 8; i++) begin
            s = ins(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                    $urandom, $urandom, $urandom, $urandom);
            if (s.op == 2'b10) begin
                fl = functs[$urandom_range(0, 5)];
                s.se[5:0] = fl;
            end
            s.wb = 2'($urandom); s.mr = 1'($urandom); s.mw = 1'($urandom);
            s.rt = 5'($urandom); s.rd = 5'($urandom);
            do_op($sformatf("rand%0d", i), s);
        end

        // Full mult: 33 stalled cycles, then the product with its controls intact.
        m.wb = 2'b11; m.mr = 1'b1; m.mw = 1'b1; m.br = 1'b0;
        mult_stall("mult", m, 33);
        #1 check("mult.done_stall", {31'd0, stall}, 32'd0);
        sb_q.push_back(model("mult", m));
        @(negedge clk);
        do_op("after_mult", ins(2'b00, 1'b0, 1'b1, 32'd40, 32'd2, 32'h0, 32'h20));

        // Flush during BUSY at iteration 10 (issue cycle plus counts 0..9 are stalled).
        mult_stall("mflush", m, 11);
        flush = 1'b1;
        sb_q.push_back(marker(E_ZERO, "mflush.zero"));
        @(negedge clk);
        flush = 1'b0;
        do_op("post_flush_add", ins(2'b00, 1'b0, 1'b0, 32'd11, 32'd22, 32'h0, 32'h80));
        do_op("post_flush_sub", ins(2'b01, 1'b0, 1'b1, 32'd30, 32'd8, 32'h5, 32'h84));

        // A flush that coincides with a mult decode in IDLE must not issue it.
        do_flush_op("flush_mult_idle", m);
        do_op("after_flush_idle", ins(2'b10, 1'b0, 1'b1, 32'd6, 32'd7, 32'h20, 32'h90));
        // A flush on an ordinary instruction.
        do_flush_op("flush_plain", ins(2'b00, 1'b0, 1'b1, 32'd1, 32'd2, 32'h3, 32'h4));

        // Asynchronous reset between edges in the middle of BUSY.
        mult_stall("mrst", m, 6);
        #2 rst = 1'b1;
        #1 check("mrst.stall", {31'd0, stall}, 32'd0);
        check_all_zero("mrst");
        @(negedge clk);
        rst = 1'b0;
        do_op("after_rst", ins(2'b00, 1'b0, 1'b1, 32'd100, 32'd23, 32'h0, 32'h200));

        @(negedge clk);
        @(negedge clk);
        check("sb_drain", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
